serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around a single 1-bit full-adder cell with a registered carry. It accepts two N-bit operands and a carry-in on a start strobe, then adds one bit per clock, LSB first. After N cycles it presents the N-bit sum and carry-out. It is the sequential stage that drives the gate-level full adder, trading latency for area against a ripple array.

## Interface
- N, default 8, operand/sum width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  operand-load strobe; sampled on rising clk edge
- a  input  N  operand A; captured when start is accepted
- b  input  N  operand B; captured when start is accepted
- ci  input  1  carry-in; captured when start is accepted
- busy  output  1  high while bits are being added
- done  output  1  one-cycle pulse: s/co (and ovf) valid
- s  output  N  sum; holds until the next accepted start
- co  output  1  carry-out; holds with s
- ovf  output  1  two's-complement overflow; present only with SERIAL_ADDER_OVF_EN

## Operation
- Reset: one clock, asynchronous, active-low (rst_n). State goes to IDLE. busy=0, done=0, s=0, co=0, ovf=0. The operand shift registers, carry register and bit counter all clear.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Load a→A shift register, b→B shift register, ci→carry register.
  - Counter=0; go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - sum bit = A[0]^B[0]^c; next c = A[0]&B[0] | B[0]&c | A[0]&c.
  - Shift A and B right by one.
  - Shift the sum register right, inserting the sum bit at the MSB.
  - Counter increments.
- RUN, counter = N-1: the last bit is processed, co is loaded with the final carry, and the state goes to DONE.
- s updates only when entering DONE. The internal sum register is separate, so s never shows partial results.
- start in RUN is ignored; the in-flight operation is unaffected.
- rst_n low at any time aborts immediately. No done pulse is produced, and all outputs return to their reset values.
- Arithmetic is unsigned modulo 2^N with carry-out: {co,s} = a + b + ci exactly.

## Timing
- Start accepted at edge E0. Bit i is processed at edge E(i+1). The state is DONE after edge EN.
- done is high for exactly the cycle between EN and E(N+1). s/co are valid from EN onward.
- Latency from the start edge to done: N clocks. Throughput with start held high: one result per N+1 clocks.
- busy is high from E0 to EN, i.e. N cycles, and is low in DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf port exists.
  - ovf = (carry into bit N-1) ^ (carry out of bit N-1), registered on entering DONE.
  - ovf holds with s.
- SERIAL_ADDER_OVF_EN undefined: no ovf port and no overflow logic. Everything else is identical.

## Test plan
- Reset/abort (N=8): drive rst_n low 3 cycles after start with a=0x55, b=0x33 → busy=0, done=0, s=0x00, co=0 immediately. No done pulse follows.
- 0xFF + 0x01, ci=0 → done exactly 8 clocks after the start edge, s=0x00, co=1, ovf=0.
- 0x7F + 0x01, ci=0 → s=0x80, co=0, ovf=1 (with macro). Without the macro: same s/co and no ovf port.
- 0xA5 + 0x5A, ci=1 → s=0x00, co=1, ovf=0. Then pulse start mid-RUN with a=0x01, b=0x01 → ignored, and s stays 0x00 after done.
- start held high with a new operand each accepted start: 0x10+0x20 → 0x30, then 0x80+0x80 → 0x00 with co=1. done pulses are 9 clocks apart.
- N=4 exhaustive: all 512 combinations of a, b, ci → {co,s} == a+b+ci, each with exactly one done pulse.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built from one 1-bit full-adder cell with a registered carry.
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i/a_i/b_i/ci_i load an operation;
//        busy_o while bits are added, done_o one-cycle result strobe, s_o/co_o result held until next start.
// Latency: N clocks from the accepting edge to done_o; throughput one result per N+1 clocks with start held.
// Backpressure: none; start_i is ignored while busy, and result registers hold until the next accepted start.
// Optional feature: define SERIAL_ADDER_OVF_EN to add ovf_o (two's-complement overflow, held with s_o).
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         ci_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] s_o,
  output logic         co_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          c_q, c_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  s_q, s_d;
  logic          co_q, co_d;
  logic          sum_bit;
  logic          c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  // The single full-adder cell, always looking at the current LSBs and carry.
  always_comb begin
    sum_bit = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt   = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (a_q[0] & c_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = ci_i;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        sum_d = {sum_bit, sum_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish only the completed word so s_o never shows partial sums.
          s_d     = {sum_bit, sum_q[N-1:1]};
          co_d    = c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB differs from carry out of it exactly on signed overflow.
          ovf_d   = c_q ^ c_nxt;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status outputs decode the state register directly; no input reaches an output combinationally.
  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign s_o    = s_q;
  assign co_o   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (N=8 instance plus an N=4 instance for exhaustive sums).
// Reference results come from plain integer arithmetic on the operands.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8;
  logic [7:0] s8;

  logic       start4 = 1'b0, ci4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, co4;
  logic [3:0] s4;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done4_pulses = 0;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) u8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .ci_i(ci8),
    .busy_o(busy8), .done_o(done8), .s_o(s8), .co_o(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf8)
`endif
  );

  serial_adder #(.N(4)) u4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .a_i(a4), .b_i(b4), .ci_i(ci4),
    .busy_o(busy4), .done_o(done4), .s_o(s4), .co_o(co4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf4)
`endif
  );

  // A done pulse lasts one cycle, so one sample per cycle counts each pulse once.
  always @(negedge clk) if (done4) done4_pulses++;

  // Reference: 9-bit unsigned sum and signed-range overflow of an 8-bit add.
  function automatic logic [8:0] ref_sum8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    return 9'(int'(a) + int'(b) + int'(ci));
  endfunction

  function automatic logic ref_ovf8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int sa, sb, r;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    r  = sa + sb + int'(ci);
    return (r > 127) || (r < -128);
  endfunction

  // Starts one op on the 8-bit instance and returns clocks from the accepting edge to done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check8(input string name, input logic [7:0] a, input logic [7:0] b, input logic ci, input int lat);
    logic [8:0] exp;
    exp = ref_sum8(a, b, ci);
    chk_cnt++;
    if (lat !== 8) $display("FAIL %s latency: got %0d, want 8", name, lat);
    else pass_cnt++;
    chk_cnt++;
    if ({co8, s8} !== exp) $display("FAIL %s sum: got co=%0b s=%02h, want co=%0b s=%02h", name, co8, s8, exp[8], exp[7:0]);
    else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
    chk_cnt++;
    if (ovf8 !== ref_ovf8(a, b, ci)) $display("FAIL %s ovf: got %0b, want %0b", name, ovf8, ref_ovf8(a, b, ci));
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if ({busy8, done8, co8, s8} !== 11'h0) $display("FAIL reset8: got busy=%0b done=%0b co=%0b s=%02h, want all 0", busy8, done8, co8, s8);
    else pass_cnt++;
    chk_cnt++;
    if ({busy4, done4, co4, s4} !== 7'h0) $display("FAIL reset4: got busy=%0b done=%0b co=%0b s=%0h, want all 0", busy4, done4, co4, s4);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_abort();
    int seen;
    // Leave a nonzero result behind so the abort visibly clears it.
    int lat;
    run8(8'h12, 8'h34, 1'b0, lat);
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h33; ci8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    chk_cnt++;
    if (busy8 !== 1'b1) $display("FAIL abort busy_after_start: got %0b, want 1", busy8);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk_cnt++;
    if ({busy8, done8, co8, s8} !== 11'h0) $display("FAIL abort outputs: got busy=%0b done=%0b co=%0b s=%02h, want all 0", busy8, done8, co8, s8);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (14) begin @(negedge clk); if (done8) seen++; end
    chk_cnt++;
    if (seen !== 0) $display("FAIL abort no_done: got %0d pulses, want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    int lat;
    run8(8'hFF, 8'h01, 1'b0, lat);
    check8("ff_01", 8'hFF, 8'h01, 1'b0, lat);
    chk_cnt++;
    if (busy8 !== 1'b0) $display("FAIL busy_in_done: got %0b, want 0", busy8);
    else pass_cnt++;
    run8(8'h7F, 8'h01, 1'b0, lat);
    check8("7f_01", 8'h7F, 8'h01, 1'b0, lat);
  endtask

  task automatic test_start_ignored();
    int lat, seen;
    logic [7:0] held;
    held = s8;
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; ci8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    chk_cnt++;
    if (s8 !== held) $display("FAIL s_holds_midrun: got %02h, want %02h", s8, held);
    else pass_cnt++;
    lat = 4;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    check8("a5_5a_ignore", 8'hA5, 8'h5A, 1'b1, lat);
    seen = 0;
    repeat (12) begin @(negedge clk); if (done8) seen++; end
    chk_cnt++;
    if (seen !== 1) $display("FAIL ignored_start_no_extra_done: got %0d pulses, want 1", seen);
    else pass_cnt++;
    chk_cnt++;
    if (s8 !== 8'h00) $display("FAIL ignored_start_s: got %02h, want 00", s8);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80;
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    check8("b2b_first", 8'h10, 8'h20, 1'b0, lat);
    gap = 0;
    @(posedge clk); #1; gap++;
    while (!done8 && gap < 40) begin @(posedge clk); #1; gap++; end
    start8 = 1'b0;
    chk_cnt++;
    if (gap !== 9) $display("FAIL b2b_gap: got %0d, want 9", gap);
    else pass_cnt++;
    chk_cnt++;
    if ({co8, s8} !== ref_sum8(8'h80, 8'h80, 1'b0)) $display("FAIL b2b_second: got co=%0b s=%02h, want co=1 s=00", co8, s8);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] a, b;
    logic ci;
    for (int i = 0; i < 24; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom_range(0, 1));
      run8(a, b, ci, lat);
      check8("random", a, b, ci, lat);
    end
  endtask

  task automatic test_exhaustive_n4();
    int lat, base;
    logic [4:0] exp;
    base = done4_pulses;
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      a4 = 4'(v >> 5); b4 = 4'(v >> 1); ci4 = v[0]; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
      exp = 5'(int'(a4) + int'(b4) + int'(ci4));
      chk_cnt++;
      if (lat !== 4 || {co4, s4} !== exp)
        $display("FAIL n4 a=%0h b=%0h ci=%0b: got lat=%0d co=%0b s=%0h, want lat=4 co=%0b s=%0h", a4, b4, ci4, lat, co4, s4, exp[4], exp[3:0]);
      else pass_cnt++;
    end
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (done4_pulses - base !== 512) $display("FAIL n4 pulse_count: got %0d, want 512", done4_pulses - base);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_abort();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_exhaustive_n4();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
